rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters, such as a shared SPI/display bus or a shared accumulator port.
- Selection uses a masked lowest-set-bit priority search above the last winner, wrapping to a full lowest-set-bit search when nothing is found above it.
- A grant is held until the owner drops its request or an optional hold limit expires.
- Sits between requesting engines and the shared-resource mux; grant_idx drives the mux select directly.

Parameters:
N, 8, number of requesters; legal range 2..32.
HOLD_LIMIT, 0, max consecutive grant cycles per ownership; 0 = unlimited.
CNTW, 16, width of the hold counter; HOLD_LIMIT must be < 2**CNTW.

Ports:
clk  in  1  system clock, all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
req  in  N  per-requester request level; held high for as long as ownership is wanted.
grant  out  N  one-hot grant, registered; all-zero when no owner.
grant_idx  out  $clog2(N)  index of current owner; valid only when grant_valid=1.
grant_valid  out  1  high while any grant bit is high.
preempt  out  1  one-cycle pulse when an ownership is ended by HOLD_LIMIT.

Behaviour:
- Internal widths: idx width IW=$clog2(N); ptr[IW-1:0] holds the last winner.

Reset (asynchronous, reset_n=0):
- grant=0, grant_idx=0, grant_valid=0, preempt=0.
- ptr=N-1, so index 0 has top priority on the first arbitration.
- hold counter=0; state=IDLE.
- Reset may assert in any state. Outputs clear immediately, not at the next edge. No partial grant survives.

FSM states:
- IDLE:
  - At the edge where req!=0, compute mask = bits strictly above ptr.
  - win = lowest set bit of (req & mask) if nonzero, else lowest set bit of req.
  - Register grant=onehot(win), grant_idx=win, grant_valid=1, ptr=win, count=1. Go to OWN.
  - If req==0, stay in IDLE with outputs zero.
- OWN:
  - If req[grant_idx]==0 at the edge: clear grant, go to GAP. preempt stays 0.
  - Else if HOLD_LIMIT!=0 and count==HOLD_LIMIT: clear grant, pulse preempt=1 for exactly one cycle, go to GAP.
  - Else count++, saturating at 2**CNTW-1.
  - Request-drop takes precedence over limit expiry in the same cycle; preempt=0 in that case.
- GAP:
  - One mandatory dead cycle with grant=0. This gives mux/bus turnaround and guarantees no back-to-back overlap.
  - Next edge: go to IDLE. Arbitration happens from IDLE; GAP never grants.

Latency and timing:
- Request to grant: 1 edge from IDLE. A req high before edge k gives grant visible after edge k.
- Minimum handoff gap between two owners is 2 cycles with grant=0: GAP, then the IDLE arbitration edge.

Fairness and requester rules:
- Every continuously requesting requester is granted within N ownerships.
- A preempted requester that keeps req high is eligible again, but ranks behind all indices above it.
- Requests from non-owners during OWN are ignored. No queuing state is kept beyond ptr.
- grant_idx and grant are always consistent; grant is never multi-hot.
- req may glitch between edges; only edge-sampled values matter.

Test Plan:
- Reset, then req=8'b0010_0100 -> after 1 edge grant=8'b0000_0100, grant_idx=2, grant_valid=1; hold req 5 cycles -> grant unchanged, preempt=0.
- Owner 2 drops req while req[5]=1 -> next edge grant=0 (GAP), then IDLE edge, then grant=8'b0010_0000, grant_idx=5.
- Wrap: ptr=6 after granting 6 and releasing; req=8'b0000_0011 -> grant_idx=0, then after 0 releases -> grant_idx=1.
- HOLD_LIMIT=4, req=8'hFF held forever -> owners 0,1,2,…,7,0 each exactly 4 grant cycles; preempt pulses once per handoff; 2 zero-grant cycles between owners; never multi-hot.
- Simultaneous: with HOLD_LIMIT=4, owner drops req on the cycle count==4 -> preempt stays 0, normal GAP.
- Reset mid-ownership: reset_n=0 while grant_idx=3 -> grant, grant_valid, preempt go 0 immediately (before next clk edge). Release reset with req=8'b0000_1010 -> first grant goes to idx 1.
- HOLD_LIMIT=0, single requester 7 held 1000 cycles -> grant_idx=7 throughout, preempt never asserts.

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and optional hold limit
//
// Shares one resource among N requesters. The next owner is the lowest
// requester above the last winner. If none is requesting there, the search
// wraps to the lowest requester overall. An ownership lasts until the owner
// drops its request, or until HOLD_LIMIT grant cycles have elapsed. Each
// ownership is followed by one dead GAP cycle before the next arbitration.
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   req         per-requester request level
//   grant       registered one-hot grant, zero when there is no owner
//   grant_idx   index of current owner, meaningful while grant_valid=1
//   grant_valid high while any grant bit is high
//   preempt     one-cycle pulse when an ownership is ended by the hold limit
module rr_arbiter #(
  parameter int N          = 8,
  parameter int HOLD_LIMIT = 0,
  parameter int CNTW       = 16,
  localparam int IW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid,
  output logic          preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] HOLD_CNT = CNTW'(HOLD_LIMIT);

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [CNTW-1:0] count, count_n;
  logic [N-1:0]    grant_n;
  logic [IW-1:0]   grant_idx_n;
  logic            grant_valid_n;
  logic            preempt_n;

  logic [N-1:0]    mask;
  logic [N-1:0]    masked_req;
  logic [IW-1:0]   win;

  function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    // Scan downwards so the last hit, the lowest index, is the one kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Bits strictly above the last winner. This is a per-bit compare rather than
  // a shift, so ptr=N-1 yields an empty mask even when N is a power of two.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i > int'(ptr));
    end
  end

  assign masked_req = req & mask;
  assign win        = (|masked_req) ? lowest_set(masked_req) : lowest_set(req);

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    count_n       = count;
    grant_n       = grant;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
    preempt_n     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n       = N'(1) << win;
          grant_idx_n   = win;
          grant_valid_n = 1'b1;
          ptr_n         = win;
          count_n       = CNTW'(1);
          state_n       = OWN;
        end
      end
      OWN: begin
        // A request drop wins over limit expiry, so no preempt is raised then.
        if (!req[grant_idx]) begin
          grant_n       = '0;
          grant_valid_n = 1'b0;
          state_n       = GAP;
        end else if ((HOLD_LIMIT != 0) && (count == HOLD_CNT)) begin
          grant_n       = '0;
          grant_valid_n = 1'b0;
          preempt_n     = 1'b1;
          state_n       = GAP;
        end else if (count != '1) begin
          count_n = count + 1'b1;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        grant_n       = '0;
        grant_valid_n = 1'b0;
        state_n       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= IW'(N - 1);
      count       <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      count       <= count_n;
      grant       <= grant_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= grant_valid_n;
      preempt     <= preempt_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter, unlimited and HOLD_LIMIT=4 instances
module tb_rr_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req_a, req_b;
  logic [N-1:0] grant_a, grant_b;
  logic [2:0]   idx_a, idx_b;
  logic         valid_a, valid_b, pre_a, pre_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0=idle, 1=owned, 2=dead cycle.
  int m_phase[2];
  int m_own[2];
  int m_cnt[2];
  int m_last[2];
  int m_pre[2];
  int lim[2] = '{0, 4};

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .HOLD_LIMIT(0), .CNTW(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .grant(grant_a),
    .grant_idx(idx_a), .grant_valid(valid_a), .preempt(pre_a)
  );

  rr_arbiter #(.N(N), .HOLD_LIMIT(4), .CNTW(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .grant(grant_b),
    .grant_idx(idx_b), .grant_valid(valid_b), .preempt(pre_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_own[d]   = 0;
      m_cnt[d]   = 0;
      m_last[d]  = N - 1;
      m_pre[d]   = 0;
    end
  endtask

  // Rotating search starting just after the last winner.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input int d, input logic [N-1:0] r);
    m_pre[d] = 0;
    case (m_phase[d])
      0: if (r != 0) begin
        m_own[d]   = pick(r, m_last[d]);
        m_last[d]  = m_own[d];
        m_cnt[d]   = 1;
        m_phase[d] = 1;
      end
      1: begin
        if (!r[m_own[d]]) m_phase[d] = 2;
        else if (lim[d] != 0 && m_cnt[d] == lim[d]) begin
          m_phase[d] = 2;
          m_pre[d]   = 1;
        end else m_cnt[d]++;
      end
      default: m_phase[d] = 0;
    endcase
  endtask

  task automatic check_dut(input int d);
    logic [N-1:0] g;
    logic [2:0]   ix;
    logic         v, p;
    logic [N-1:0] eg;
    string        s;
    s  = (d == 0) ? "a" : "b";
    g  = (d == 0) ? grant_a : grant_b;
    ix = (d == 0) ? idx_a   : idx_b;
    v  = (d == 0) ? valid_a : valid_b;
    p  = (d == 0) ? pre_a   : pre_b;
    eg = (m_phase[d] == 1) ? (N'(1) << m_own[d]) : '0;
    chk({s, ".grant"}, 32'(g), 32'(eg));
    chk({s, ".valid"}, 32'(v), (m_phase[d] == 1) ? 32'd1 : 32'd0);
    chk({s, ".preempt"}, 32'(p), 32'(m_pre[d]));
    chk({s, ".onehot0"}, 32'($onehot0(g)), 32'd1);
    if (m_phase[d] == 1) chk({s, ".idx"}, 32'(ix), 32'(m_own[d]));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) begin
      model_edge(0, req_a);
      model_edge(1, req_b);
    end else begin
      model_reset();
    end
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    int per_owner[N];
    int pre_count;
    int reached;

    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    model_reset();
    repeat (2) step();
    chk("reset.idx_a", 32'(idx_a), 32'd0);
    chk("reset.idx_b", 32'(idx_b), 32'd0);
    #2 reset_n = 1'b1;

    // Basic grant and hold.
    req_a = 8'b0010_0100;
    step();
    chk("t1.grant", 32'(grant_a), 32'h04);
    chk("t1.idx", 32'(idx_a), 32'd2);
    repeat (5) step();
    chk("t1.hold", 32'(grant_a), 32'h04);
    chk("t1.pre", 32'(pre_a), 32'd0);

    // Handoff through GAP and IDLE.
    req_a = 8'b0010_0000;
    step();
    chk("t2.gap", 32'(grant_a), 32'h00);
    step();
    chk("t2.idle", 32'(grant_a), 32'h00);
    step();
    chk("t2.grant", 32'(grant_a), 32'h20);
    chk("t2.idx", 32'(idx_a), 32'd5);

    // Wrap-around after granting 6.
    req_a = 8'h40;
    repeat (3) step();
    chk("t3.idx6", 32'(idx_a), 32'd6);
    req_a = 8'h03;
    repeat (3) step();
    chk("t3.idx0", 32'(idx_a), 32'd0);
    req_a = 8'h02;
    repeat (3) step();
    chk("t3.idx1", 32'(idx_a), 32'd1);
    req_a = '0;
    repeat (2) step();

    // HOLD_LIMIT=4, all requesting: 6-cycle period per owner.
    req_b     = 8'hFF;
    pre_count = 0;
    for (int i = 0; i < N; i++) per_owner[i] = 0;
    repeat (N * 6) begin
      step();
      if (pre_b) pre_count++;
      if (valid_b) per_owner[idx_b]++;
    end
    chk("t4.preempts", 32'(pre_count), 32'd8);
    for (int i = 0; i < N; i++) chk($sformatf("t4.cycles%0d", i), 32'(per_owner[i]), 32'd4);

    // Drop on the same edge the limit would expire.
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      step();
      if (m_phase[1] == 1 && m_cnt[1] == 4) reached = 1;
    end
    chk("t5.reach", 32'(reached), 32'd1);
    req_b[idx_b] = 1'b0;
    step();
    chk("t5.pre", 32'(pre_b), 32'd0);
    chk("t5.grant", 32'(grant_b), 32'h00);
    req_b = '0;
    repeat (2) step();

    // Asynchronous reset mid-ownership.
    req_a   = 8'h08;
    reached = 0;
    for (int i = 0; i < 10 && reached == 0; i++) begin
      step();
      if (valid_a && idx_a == 3'd3) reached = 1;
    end
    chk("t6.own3", 32'(reached), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6.grant", 32'(grant_a), 32'h00);
    chk("t6.valid", 32'(valid_a), 32'd0);
    chk("t6.pre", 32'(pre_a), 32'd0);
    check_dut(0);
    check_dut(1);
    step();
    req_a = 8'b0000_1010;
    #2 reset_n = 1'b1;
    step();
    chk("t6.idx1", 32'(idx_a), 32'd1);

    // Unlimited hold, single requester 7.
    req_a = 8'h80;
    repeat (3) step();
    repeat (1000) begin
      step();
      chk("t7.idx", 32'(idx_a), 32'd7);
      chk("t7.pre", 32'(pre_a), 32'd0);
    end
    req_a = '0;
    repeat (2) step();

    // Random traffic on both instances.
    repeat (400) begin
      req_a = N'($urandom & $urandom);
      req_b = N'($urandom & $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
